// File: rtl/reduction_eject_buffer_pkg.sv
// Shared flit width and sizing helpers for the reduction ejection buffer.
// Latency: none (declarations only); backpressure: n/a.
package reduction_eject_buffer_pkg;

    localparam int FLIT_SIZE = 32;

    // Counter width that stays at least one bit, even when only one value is needed.
    function automatic int cnt_w(input int n);
        return ($clog2(n) > 0) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reduction_eject_buffer_eject_fifo.sv
// DEPTH-entry FWFT flit FIFO with registered in_avail/out_valid and head register.
// Latency: 1 cycle from enqueue to out_valid; backpressure: in_avail drops exactly at full, head holds while stalled.
module eject_fifo
    import reduction_eject_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = FLIT_SIZE
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [W-1:0]                 in_i,
    input  logic                         in_valid_i,
    output logic                         in_avail_o,
    output logic [W-1:0]                 out_o,
    output logic                         out_valid_o,
    input  logic                         out_avail_i,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
    output logic                         deq_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_avail_q, in_avail_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_q, out_d;
    logic [W-1:0]  head_d;
    logic          enq, deq;

    assign enq = in_valid_i & in_avail_q;
    assign deq = out_valid_q & out_avail_i;

    always_comb begin
        wptr_d = wptr_q + AW'(enq);
        rptr_d = rptr_q + AW'(deq);
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A lone surviving entry that is being written this edge is not in storage yet.
        head_d      = (enq && (count_d == CW'(1))) ? in_i : mem_q[rptr_d];
        out_valid_d = (count_d != CW'(0));
        out_d       = out_valid_d ? head_d : out_q;
        in_avail_d  = (count_d != CW'(DEPTH));
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q] <= in_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            in_avail_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            in_avail_q  <= in_avail_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign in_avail_o  = in_avail_q;
    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign occupancy_o = count_q;
    assign deq_o       = deq;

endmodule

// File: rtl/reduction_eject_buffer.sv
// Buffers the reduction-tree flit stream toward ejection and marks every ROUND_LEN departures as a round.
// Latency: 1 cycle FWFT, round_done 1 cycle after the closing dequeue; backpressure: via eject_fifo in_avail/out_avail.
module reduction_eject_buffer
    import reduction_eject_buffer_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int ROUND_LEN  = 54,
    parameter int ROUND_ID_W = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [FLIT_SIZE-1:0]         in_i,
    input  logic                         in_valid_i,
    output logic                         in_avail_o,
    output logic [FLIT_SIZE-1:0]         out_o,
    output logic                         out_valid_o,
    input  logic                         out_avail_i,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
    output logic                         round_done_o,
    output logic [ROUND_ID_W-1:0]        round_id_o
);

    localparam int RC_W = cnt_w(ROUND_LEN);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(ROUND_LEN - 1);

    logic                  deq;
    logic [RC_W-1:0]       rc_q, rc_d;
    logic [ROUND_ID_W-1:0] round_id_q, round_id_d;
    logic                  round_done_q, round_done_d;

    eject_fifo #(
        .DEPTH (DEPTH),
        .W     (FLIT_SIZE)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_i        (in_i),
        .in_valid_i  (in_valid_i),
        .in_avail_o  (in_avail_o),
        .out_o       (out_o),
        .out_valid_o (out_valid_o),
        .out_avail_i (out_avail_i),
        .occupancy_o (occupancy_o),
        .deq_o       (deq)
    );

    always_comb begin
        rc_d         = rc_q;
        round_id_d   = round_id_q;
        round_done_d = 1'b0;
        if (deq) begin
            if (rc_q == RC_LAST) begin
                rc_d         = '0;
                round_id_d   = round_id_q + ROUND_ID_W'(1);
                round_done_d = 1'b1;
            end else begin
                rc_d = rc_q + RC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rc_q         <= '0;
            round_id_q   <= '0;
            round_done_q <= 1'b0;
        end else begin
            rc_q         <= rc_d;
            round_id_q   <= round_id_d;
            round_done_q <= round_done_d;
        end
    end

    assign round_done_o = round_done_q;
    assign round_id_o   = round_id_q;

endmodule

// File: tb/tb_reduction_eject_buffer.sv
// Self-checking bench: queue-based reference model plus directed literal expectations.
module tb_reduction_eject_buffer;
    import reduction_eject_buffer_pkg::*;

    localparam int DEPTH = 8;
    localparam int RL    = 54;
    localparam int IDW   = 4;
    localparam int OCW   = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [FLIT_SIZE-1:0] in_d = '0;
    logic                 in_valid = 1'b0;
    logic                 out_avail = 1'b0;
    logic                 in_avail;
    logic [FLIT_SIZE-1:0] out_d;
    logic                 out_valid;
    logic [OCW-1:0]       occupancy;
    logic                 round_done;
    logic [IDW-1:0]       round_id;

    reduction_eject_buffer #(.DEPTH(DEPTH), .ROUND_LEN(RL), .ROUND_ID_W(IDW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_i         (in_d),
        .in_valid_i   (in_valid),
        .in_avail_o   (in_avail),
        .out_o        (out_d),
        .out_valid_o  (out_valid),
        .out_avail_i  (out_avail),
        .occupancy_o  (occupancy),
        .round_done_o (round_done),
        .round_id_o   (round_id)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: a plain queue of flits and a running departure count.
    logic [FLIT_SIZE-1:0] mq[$];
    bit m_avail, m_done, m_e, m_d;
    int m_deq, m_id;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_avail = 0; m_done = 0; m_deq = 0; m_id = 0;
        end else begin
            m_e = in_valid && m_avail;
            m_d = out_avail && (mq.size() != 0);
            m_done = 0;
            if (m_d) begin
                void'(mq.pop_front());
                m_deq++;
                if (m_deq % RL == 0) begin
                    m_done = 1;
                    m_id = (m_id + 1) % (1 << IDW);
                end
            end
            if (m_e) mq.push_back(in_d);
            m_avail = (mq.size() != DEPTH);
        end
    end

    int pulses = 0;
    int pulse_at[$];
    int max_occ = 0;

    always @(negedge clk) begin
        chk("in_avail", in_avail, m_avail);
        chk("out_valid", out_valid, mq.size() != 0);
        chk("occupancy", occupancy, mq.size());
        if (mq.size() != 0) chk("out", out_d, mq[0]);
        chk("round_done", round_done, m_done);
        chk("round_id", round_id, m_id);
        if (!rst_n) begin
            pulses = 0;
            pulse_at.delete();
        end else if (round_done) begin
            pulses++;
            pulse_at.push_back(m_deq);
        end
        if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; in_valid = 0; out_avail = 0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        logic [FLIT_SIZE-1:0] got[$];
        logic [FLIT_SIZE-1:0] cnt;

        // 1: reset state, single flit 0xA5
        do_reset();
        chk("t1 in_avail before edge", in_avail, 0);
        chk("t1 out reset", out_d, 0);
        chk("t1 occ reset", occupancy, 0);
        step();
        chk("t1 in_avail after edge", in_avail, 1);
        in_d = 32'hA5; in_valid = 1; out_avail = 1;
        step();
        in_valid = 0;
        chk("t1 out_valid", out_valid, 1);
        chk("t1 out", out_d, 32'hA5);
        chk("t1 occ one", occupancy, 1);
        step();
        chk("t1 occ zero", occupancy, 0);
        chk("t1 out_valid low", out_valid, 0);

        // 2: fill to full with output stalled, then drain
        out_avail = 0;
        for (int i = 1; i <= DEPTH; i++) begin
            in_d = i; in_valid = 1;
            step();
        end
        in_valid = 0;
        chk("t2 in_avail full", in_avail, 0);
        chk("t2 occ full", occupancy, DEPTH);
        out_avail = 1;
        for (int c = 0; c < 20 && got.size() < DEPTH; c++) begin
            if (out_valid) got.push_back(out_d);
            step();
            if (c == 0) chk("t2 in_avail after deq", in_avail, 1);
        end
        chk("t2 drained count", got.size(), DEPTH);
        for (int i = 0; i < got.size(); i++) chk("t2 order", got[i], i + 1);

        // 3: streaming at full rate, occupancy pinned at one
        in_valid = 1; out_avail = 1;
        for (int c = 0; c < 100; c++) begin
            in_d = 1000 + c;
            step();
            chk("t3 occ", occupancy, 1);
            chk("t3 out_valid", out_valid, 1);
            chk("t3 out", out_d, 1000 + c);
        end
        in_valid = 0;
        step();

        // 4: round tracking over 108 and then 918 departures
        do_reset();
        cnt = 0; in_valid = 1; out_avail = 1;
        for (int c = 0; c < 2000 && m_deq < 108; c++) begin
            in_d = cnt; cnt++;
            step();
        end
        chk("t4 deq count 108", m_deq, 108);
        chk("t4 round_id 2", round_id, 2);
        chk("t4 pulses 2", pulses, 2);
        if (pulse_at.size() >= 2) begin
            chk("t4 first pulse", pulse_at[0], 54);
            chk("t4 second pulse", pulse_at[1], 108);
        end
        for (int c = 0; c < 2000 && m_deq < 17 * RL; c++) begin
            in_d = cnt; cnt++;
            step();
        end
        chk("t4 deq count 918", m_deq, 17 * RL);
        chk("t4 round_id wrap", round_id, 1);
        chk("t4 pulses 17", pulses, 17);

        // 5: asynchronous reset with five flits stored
        in_valid = 0;
        repeat (4) step();
        out_avail = 0;
        for (int i = 0; i < 5; i++) begin
            in_d = 32'h50 + i; in_valid = 1;
            step();
        end
        in_valid = 0;
        chk("t5 occ five", occupancy, 5);
        #2 rst_n = 0;
        #1;
        chk("t5 out_valid async", out_valid, 0);
        chk("t5 in_avail async", in_avail, 0);
        chk("t5 occ async", occupancy, 0);
        step();
        rst_n = 1;
        step();
        in_d = 32'h3C; in_valid = 1; out_avail = 1;
        step();
        in_valid = 0;
        chk("t5 first after reset", out_d, 32'h3C);
        chk("t5 valid after reset", out_valid, 1);
        step();

        // 6: random traffic against the model
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_avail = 1'($urandom_range(0, 1));
            in_d      = $urandom;
            step();
        end
        chk("t6 max occ within depth", max_occ <= DEPTH, 1);

        in_valid = 0; out_avail = 0;
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
